// File: rtl/mult8_seq_pkg.sv
// Shared types and step tables for the sequenced 8x8 multiplier controller.
package mult8_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int NUM_STEPS = 4;

  typedef logic [NUM_STEPS-1:0] step_mask_t;
  typedef logic [1:0]           step_idx_t;

  // Which nibble of each operand feeds the core for a given step
  typedef struct packed {
    logic a_hi;
    logic b_hi;
  } step_sel_t;

  function automatic step_sel_t step_sel(input step_idx_t idx);
    step_sel_t s;
    s.a_hi = idx[1];
    s.b_hi = idx[0];
    return s;
  endfunction

  // Left shift in units of HALF bits: {0, HALF, HALF, WIDTH}
  function automatic logic [1:0] step_shift_units(input step_idx_t idx);
    case (idx)
      2'd0:    return 2'd0;
      2'd3:    return 2'd2;
      default: return 2'd1;
    endcase
  endfunction

  // Lowest pending step; steps are always visited in ascending order
  function automatic step_idx_t first_step(input step_mask_t m);
    step_idx_t r;
    r = '0;
    for (int i = NUM_STEPS - 1; i >= 0; i--) begin
      if (m[i]) r = step_idx_t'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/mult8_seq_ctrl_core.sv
// Combinational HALF x HALF unsigned multiplier shared by all steps.
module mult4_core #(
  parameter int HALF = 4
) (
  input  logic [HALF-1:0]   x_i,
  input  logic [HALF-1:0]   y_i,
  output logic [2*HALF-1:0] prod_o
);

  assign prod_o = (2*HALF)'(x_i) * (2*HALF)'(y_i);

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Sequenced WIDTH x WIDTH multiplier time-sharing one HALF x HALF core.
// Optional MULT8_SEQ_ZERO_SKIP_EN skips steps whose nibble pair contains a zero.
module mult8_seq_ctrl
  import mult8_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int PROD_W = 2 * WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] p,
  output logic              busy
);

  localparam int HALF = WIDTH / 2;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [PROD_W-1:0]  acc_q, acc_d;
  logic [PROD_W-1:0]  p_q, p_d;
  step_mask_t         mask_q, mask_d;

  step_mask_t         accept_mask;
  step_mask_t         rem_mask;
  step_idx_t          idx;
  step_sel_t          sel;
  logic [HALF-1:0]    core_x, core_y;
  logic [2*HALF-1:0]  pp;
  logic [PROD_W-1:0]  pp_ext;
  logic [PROD_W-1:0]  term;
  logic [PROD_W-1:0]  acc_sum;

`ifdef MULT8_SEQ_ZERO_SKIP_EN
  logic a_lo_nz, a_hi_nz, b_lo_nz, b_hi_nz;

  assign a_lo_nz = |a[HALF-1:0];
  assign a_hi_nz = |a[WIDTH-1:HALF];
  assign b_lo_nz = |b[HALF-1:0];
  assign b_hi_nz = |b[WIDTH-1:HALF];

  assign accept_mask = {a_hi_nz & b_hi_nz, a_hi_nz & b_lo_nz,
                        a_lo_nz & b_hi_nz, a_lo_nz & b_lo_nz};
`else
  assign accept_mask = '1;
`endif

  // Core operands come only from the latched registers, never the ports
  assign idx    = first_step(mask_q);
  assign sel    = step_sel(idx);
  assign core_x = sel.a_hi ? a_q[WIDTH-1:HALF] : a_q[HALF-1:0];
  assign core_y = sel.b_hi ? b_q[WIDTH-1:HALF] : b_q[HALF-1:0];

  mult4_core #(
    .HALF (HALF)
  ) u_core (
    .x_i    (core_x),
    .y_i    (core_y),
    .prod_o (pp)
  );

  assign pp_ext = PROD_W'(pp);

  always_comb begin
    case (step_shift_units(idx))
      2'd0:    term = pp_ext;
      2'd1:    term = pp_ext << HALF;
      default: term = pp_ext << WIDTH;
    endcase
  end

  assign acc_sum  = acc_q + term;
  assign rem_mask = mask_q & ~(step_mask_t'(1) << idx);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    p_d     = p_q;
    mask_d  = mask_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d    = a;
          b_d    = b;
          acc_d  = '0;
          mask_d = accept_mask;
          if (accept_mask == '0) begin
            p_d     = '0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_STEP;
          end
        end
      end
      ST_STEP: begin
        acc_d  = acc_sum;
        mask_d = rem_mask;
        // The last pending step writes the product directly
        if (rem_mask == '0) begin
          p_d     = acc_sum;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      mask_q  <= mask_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign p         = p_q;

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Self-checking bench for mult8_seq_ctrl against an arithmetic reference model.
module tb_mult8_seq_ctrl;

`ifdef MULT8_SEQ_ZERO_SKIP_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  a = 8'h00;
  logic [7:0]  b = 8'h00;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [15:0] p;

  int n_checks = 0;
  int n_fail   = 0;

  mult8_seq_ctrl #(.WIDTH(8), .PROD_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: product is plain a*b; cycles from accept to out_valid are
  // (number of executed nibble products) + 1.
  function automatic logic [15:0] ref_prod(input logic [7:0] x, input logic [7:0] y);
    return 16'(x) * 16'(y);
  endfunction

  function automatic int ref_lat(input logic [7:0] x, input logic [7:0] y);
    int pairs;
    int xn [2];
    int yn [2];
    pairs = 0;
    xn[0] = int'(x % 16); xn[1] = int'(x / 16);
    yn[0] = int'(y % 16); yn[1] = int'(y / 16);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        if (xn[i] != 0 && yn[j] != 0) pairs++;
    return SKIP_EN ? pairs + 1 : 5;
  endfunction

  // Drives one operation from idle; returns latency (-1 on timeout) and product.
  task automatic run_op(input logic [7:0] ai, input logic [7:0] bi, input bit early_rdy,
                        output int lat, output logic [15:0] pv, output bit rdy_ok);
    int cyc;
    a = ai; b = bi; in_valid = 1'b1; out_ready = early_rdy;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom);
    cyc = 1; rdy_ok = 1'b1;
    while (out_valid !== 1'b1 && cyc < 40) begin
      if (in_ready !== 1'b0) rdy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    if (in_ready !== 1'b0) rdy_ok = 1'b0;
    lat = (out_valid === 1'b1) ? cyc : -1;
    pv = p;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || p !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b p=%h required 1 0 0 0000",
               in_ready, out_valid, busy, p);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b busy=%b required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_directed;
    logic [7:0]  va [6] = '{8'h12, 8'hFF, 8'h00, 8'h0F, 8'h00, 8'hF0};
    logic [7:0]  vb [6] = '{8'h34, 8'hFF, 8'hAB, 8'h0F, 8'h5A, 8'h0F};
    logic [15:0] pv;
    int          lat;
    bit          rdy_ok;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vb[i], (i % 2) == 0, lat, pv, rdy_ok);
      n_checks++;
      if (pv !== ref_prod(va[i], vb[i])) begin
        n_fail++;
        $display("FAIL directed_p[%0d]: %h*%h got %h required %h", i, va[i], vb[i], pv,
                 ref_prod(va[i], vb[i]));
      end
      n_checks++;
      if (lat != ref_lat(va[i], vb[i])) begin
        n_fail++;
        $display("FAIL directed_lat[%0d]: got %0d required %0d", i, lat, ref_lat(va[i], vb[i]));
      end
      n_checks++;
      if (!rdy_ok) begin
        n_fail++;
        $display("FAIL directed_in_ready[%0d]: in_ready high while busy (required low)", i);
      end
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL directed_handoff[%0d]: out_valid=%b in_ready=%b required 0 1", i,
                 out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    a = 8'h80; b = 8'h02; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    cyc = 1;
    a = 8'h11; b = 8'h22;
    while (out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (cyc != ref_lat(8'h80, 8'h02)) begin
      n_fail++;
      $display("FAIL bp_lat: got %0d required %0d", cyc, ref_lat(8'h80, 8'h02));
    end
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (out_valid !== 1'b1 || p !== 16'h0100 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: out_valid=%b p=%h in_ready=%b required 1 0100 0", k,
                 out_valid, p, in_ready);
      end
      a = 8'($urandom); b = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b busy=%b required 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_abort;
    logic [15:0] pv;
    int          lat;
    bit          rdy_ok;
    a = 8'hAA; b = 8'h55; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_busy_before: busy=%b required 1", busy);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || p !== 16'h0000) begin
      n_fail++;
      $display("FAIL abort_reset: in_ready=%b out_valid=%b busy=%b p=%h required 1 0 0 0000",
               in_ready, out_valid, busy, p);
    end
    @(negedge clk); rst = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    run_op(8'h03, 8'h07, 1'b0, lat, pv, rdy_ok);
    n_checks++;
    if (pv !== 16'h0015) begin
      n_fail++;
      $display("FAIL abort_next_p: got %h required 0015", pv);
    end
    n_checks++;
    if (lat != ref_lat(8'h03, 8'h07)) begin
      n_fail++;
      $display("FAIL abort_next_lat: got %0d required %0d", lat, ref_lat(8'h03, 8'h07));
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] expq [$];
    logic [7:0]  x, y;
    int          next_acc;
    int          got;
    int          pushed;
    next_acc = 0; got = 0; pushed = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 80; t++) begin
      x = 8'($urandom); y = 8'($urandom);
      if ((t % 5) == 0) x = x & 8'h0F;
      if ((t % 7) == 0) y = 8'h00;
      a = x; b = y; in_valid = 1'b1;
      if (t == next_acc) begin
        expq.push_back(ref_prod(x, y));
        pushed++;
        next_acc = t + ref_lat(x, y) + 1;
      end
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        n_checks++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra: unexpected product %h", p);
        end else begin
          got++;
          if (p !== expq[0]) begin
            n_fail++;
            $display("FAIL b2b_p[%0d]: got %h required %h", got, p, expq[0]);
          end
          void'(expq.pop_front());
        end
      end
    end
    in_valid = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) begin
        n_checks++;
        if (expq.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra_drain: unexpected product %h", p);
        end else begin
          got++;
          if (p !== expq[0]) begin
            n_fail++;
            $display("FAIL b2b_p_drain[%0d]: got %h required %h", got, p, expq[0]);
          end
          void'(expq.pop_front());
        end
      end
    end
    out_ready = 1'b0;
    n_checks++;
    if (got != pushed) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d products required %0d", got, pushed);
    end
  endtask

  task automatic test_random;
    logic [7:0]  x, y;
    logic [15:0] pv;
    int          lat;
    bit          rdy_ok;
    for (int i = 0; i < 24; i++) begin
      x = 8'($urandom); y = 8'($urandom);
      case ($urandom_range(0, 4))
        0: x = x & 8'hF0;
        1: y = y & 8'h0F;
        2: begin x = x & 8'h0F; y = y & 8'hF0; end
        default: ;
      endcase
      run_op(x, y, ($urandom_range(0, 1) == 1), lat, pv, rdy_ok);
      n_checks++;
      if (pv !== ref_prod(x, y) || lat != ref_lat(x, y) || !rdy_ok) begin
        n_fail++;
        $display("FAIL random[%0d]: %h*%h p=%h lat=%0d ready_ok=%0d required p=%h lat=%0d ready_ok=1",
                 i, x, y, pv, lat, rdy_ok, ref_prod(x, y), ref_lat(x, y));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
